// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions: datapath widths, NOP encoding and fetch FSM states.
// The phase generator and decode stage import the same package.
package fetch_unit_pkg;

  localparam int DEF_PC_W    = 8;
  localparam int DEF_IR_W    = 15;
  localparam int DEF_TIMEOUT = 15;

  // All-zero instruction word decodes as a no-operation.
  localparam logic [DEF_IR_W-1:0] NOP_INSTR = 15'h0000;

  typedef enum logic [1:0] {
    FT_IDLE = 2'b00,
    FT_REQ  = 2'b01,
    FT_DONE = 2'b10
  } fetch_state_e;

  // Counter width able to hold values 0..limit; never narrower than 2 bits.
  function automatic int cnt_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    if (w < 2) begin
      w = 2;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/fetch_timer.sv
// Wait-cycle counter for an outstanding instruction fetch.
// 'expired' is high while the counter holds TIMEOUT-1, i.e. during the
// TIMEOUT-th consecutive enabled cycle since the last clear.
module fetch_timer
  import fetch_unit_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = cnt_width(DEF_TIMEOUT)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_r;

  // Count enabled wait cycles, saturating at the last one; clear restarts.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (enable && (count_r != LAST)) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LAST);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one memory read per fetch
// strobe, loads the instruction register and aborts a fetch to a NOP when
// memory does not answer within TIMEOUT cycles.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int IR_W    = DEF_IR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            FT_EN,
  input  logic            WB_EN,
  input  logic            JUMP,
  input  logic [PC_W-1:0] JUMP_ADDR,
  output logic            MEM_REQ,
  output logic [PC_W-1:0] MEM_ADDR,
  input  logic            MEM_ACK,
  input  logic [IR_W-1:0] MEM_RDATA,
  output logic [IR_W-1:0] IR,
  output logic            IR_VALID,
  output logic [PC_W-1:0] PC,
  output logic            BUSY,
  output logic            FETCH_ERR
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  fetch_state_e    state_r;
  logic [PC_W-1:0] pc_next_s;
  logic            start_fetch_s;
  logic            wait_en_s;
  logic            expired_s;

  // PC value after this cycle; a fetch started alongside WB_EN uses it.
  always_comb begin
    pc_next_s = PC;
    if (WB_EN) begin
      if (JUMP) begin
        pc_next_s = JUMP_ADDR;
      end else begin
        pc_next_s = PC + PC_ONE;
      end
    end else begin
      pc_next_s = PC;
    end
  end

  assign start_fetch_s = FT_EN && (state_r != FT_REQ);
  assign wait_en_s     = (state_r == FT_REQ) && !MEM_ACK;

  fetch_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (cnt_width(TIMEOUT))
  ) u_timer (
    .clk     (CLK),
    .reset   (RESET),
    .clear   (start_fetch_s),
    .enable  (wait_en_s),
    .expired (expired_s)
  );

  // Fetch FSM with PC commit; every output is a register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r   <= FT_IDLE;
      PC        <= {PC_W{1'b0}};
      IR        <= {IR_W{1'b0}};
      IR_VALID  <= 1'b0;
      MEM_REQ   <= 1'b0;
      MEM_ADDR  <= {PC_W{1'b0}};
      BUSY      <= 1'b0;
      FETCH_ERR <= 1'b0;
    end else begin
      PC <= pc_next_s;

      // A fetch strobe while one is outstanding is lost; remember it.
      if (FT_EN && (state_r == FT_REQ)) begin
        FETCH_ERR <= 1'b1;
      end

      case (state_r)
        FT_IDLE, FT_DONE: begin
          if (FT_EN) begin
            state_r  <= FT_REQ;
            MEM_REQ  <= 1'b1;
            MEM_ADDR <= pc_next_s;
            BUSY     <= 1'b1;
            IR_VALID <= 1'b0;
          end else if (WB_EN) begin
            IR_VALID <= 1'b0;
          end
        end

        FT_REQ: begin
          // MEM_ADDR is deliberately left alone here even if PC moves.
          if (MEM_ACK) begin
            state_r  <= FT_DONE;
            IR       <= MEM_RDATA;
            IR_VALID <= !WB_EN;
            MEM_REQ  <= 1'b0;
            BUSY     <= 1'b0;
          end else if (expired_s) begin
            state_r   <= FT_DONE;
            IR        <= IR_W'(NOP_INSTR);
            IR_VALID  <= !WB_EN;
            MEM_REQ   <= 1'b0;
            BUSY      <= 1'b0;
            FETCH_ERR <= 1'b1;
          end else if (WB_EN) begin
            IR_VALID <= 1'b0;
          end
        end

        default: begin
          state_r  <= FT_IDLE;
          MEM_REQ  <= 1'b0;
          BUSY     <= 1'b0;
          IR_VALID <= 1'b0;
        end
      endcase
    end
  end

endmodule
